// File: rtl/wr_stream_ctrl_pkg.sv
// Shared types and constants for the write-stream controller.
// Holds the FSM state type and the upstream almost-full margin.
package wr_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } wr_stream_state_t;

  localparam int unsigned AFULL_MARGIN = 4;

  function automatic int unsigned afull_level(input int unsigned depth_bits);
    return (32'd1 << depth_bits) - AFULL_MARGIN;
  endfunction

endpackage

// File: rtl/wr_stream_ctrl_syn_read_fifo.sv
// Synchronous-read FIFO: rd_data is registered on the pop edge.
// Callers qualify wr_en with !full and rd_en with !empty.
module syn_read_fifo
  import wr_stream_ctrl_pkg::*;
#(
  parameter int WIDTH      = 512,
  parameter int DEPTH_BITS = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             almostfull
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;
  localparam logic [CW-1:0] AF_LVL = CW'(afull_level(DEPTH_BITS));

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wptr;
  logic [DEPTH_BITS-1:0] rptr;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;

  assign empty = (cnt == '0);
  assign full  = cnt[DEPTH_BITS];

  // occupancy after this edge; feeds the registered almost-full flag
  always_comb begin
    cnt_nxt = cnt;
    if (wr_en && !rd_en)
      cnt_nxt = cnt + CW'(1);
    else if (!wr_en && rd_en)
      cnt_nxt = cnt - CW'(1);
    if (flush)
      cnt_nxt = '0;
  end

  // storage array, no reset
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr] <= wr_data;
  end

  // pointers, count, read register and throttle flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      rd_data    <= '0;
      almostfull <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      almostfull <= (cnt_nxt >= AF_LVL);
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_en)
          wptr <= wptr + DEPTH_BITS'(1);
        if (rd_en) begin
          rptr    <= rptr + DEPTH_BITS'(1);
          rd_data <= mem[rptr];
        end
      end
    end
  end

endmodule

// File: rtl/wr_stream_ctrl.sv
// Streams upstream cachelines into sequential write requests.
// Define WR_RSP_TRACK_EN to make done wait for all write responses.
module wr_stream_ctrl
  import wr_stream_ctrl_pkg::*;
#(
  parameter int ADDR_LMT        = 58,
  parameter int MDATA           = 14,
  parameter int CACHE_WIDTH     = 512,
  parameter int FIFO_DEPTH_BITS = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_LMT-1:0]    base_addr,
  input  logic [31:0]            num_cl,
  input  logic                   in_valid,
  input  logic [CACHE_WIDTH-1:0] in_data,
  output logic                   in_almostfull,
  output logic [ADDR_LMT-1:0]    wr_req_addr,
  output logic [MDATA-1:0]       wr_req_mdata,
  output logic [CACHE_WIDTH-1:0] wr_req_data,
  output logic                   wr_req_en,
  input  logic                   wr_req_almostfull,
  input  logic                   wr_rsp0_valid,
  input  logic [MDATA-1:0]       wr_rsp0_mdata,
  input  logic                   wr_rsp1_valid,
  input  logic [MDATA-1:0]       wr_rsp1_mdata,
  output logic                   done,
  output logic                   overflow
);

  wr_stream_state_t state;
  wr_stream_state_t state_nxt;

  logic [ADDR_LMT-1:0] base_q;
  logic [31:0]         num_q;
  logic [31:0]         pushed;
  logic [31:0]         issued;
  logic                start_ok;
  logic                push;
  logic                drop;
  logic                pop;
  logic                last_pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic                unused_rsp;

`ifdef WR_RSP_TRACK_EN
  logic [31:0] rsp_cnt;
`endif

  assign unused_rsp = ^{wr_rsp0_mdata, wr_rsp1_mdata,
                        wr_rsp0_valid, wr_rsp1_valid};

  assign start_ok = start &&
                    (state == ST_IDLE || state == ST_DONE);

  syn_read_fifo #(
    .WIDTH      (CACHE_WIDTH),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (start_ok),
    .wr_en      (push),
    .wr_data    (in_data),
    .rd_en      (pop),
    .rd_data    (wr_req_data),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .almostfull (in_almostfull)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start)
          state_nxt = (num_cl == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
`ifdef WR_RSP_TRACK_EN
        if (last_pop)
          state_nxt = ST_DRAIN;
`else
        if (wr_req_en && issued == num_q)
          state_nxt = ST_DONE;
`endif
      end
      ST_DRAIN: begin
`ifdef WR_RSP_TRACK_EN
        if (rsp_cnt >= num_q)
          state_nxt = ST_DONE;
`else
        state_nxt = ST_DONE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // push/drop/pop qualification for the current cycle
  always_comb begin
    push = 1'b0;
    drop = 1'b0;
    if (state == ST_RUN && in_valid) begin
      if (fifo_full || pushed >= num_q)
        drop = 1'b1;
      else
        push = 1'b1;
    end
    pop = (state == ST_RUN) && !fifo_empty &&
          !wr_req_almostfull && (issued < num_q);
    last_pop = pop && (issued == num_q - 32'd1);
  end

  // job registers, counters and registered request outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q       <= '0;
      num_q        <= '0;
      pushed       <= '0;
      issued       <= '0;
      wr_req_en    <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_mdata <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
`ifdef WR_RSP_TRACK_EN
      rsp_cnt      <= '0;
`endif
    end else begin
      wr_req_en <= pop;
      done      <= (state_nxt == ST_DONE);
      if (start_ok) begin
        base_q   <= base_addr;
        num_q    <= num_cl;
        pushed   <= '0;
        issued   <= '0;
        overflow <= 1'b0;
`ifdef WR_RSP_TRACK_EN
        rsp_cnt  <= '0;
`endif
      end else begin
        if (push)
          pushed <= pushed + 32'd1;
        if (drop)
          overflow <= 1'b1;
        if (pop) begin
          wr_req_addr  <= base_q + ADDR_LMT'(issued);
          wr_req_mdata <= issued[MDATA-1:0];
          issued       <= issued + 32'd1;
        end
`ifdef WR_RSP_TRACK_EN
        if (state != ST_IDLE)
          rsp_cnt <= rsp_cnt + 32'(wr_rsp0_valid) +
                     32'(wr_rsp1_valid);
`endif
      end
    end
  end

endmodule

// File: tb/tb_wr_stream_ctrl.sv
// Directed bench for wr_stream_ctrl.
// Works with or without WR_RSP_TRACK_EN defined.
module tb_wr_stream_ctrl;

  localparam int AL = 58;
  localparam int MD = 14;
  localparam int CW = 512;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AL-1:0] base_addr;
  logic [31:0]   num_cl;
  logic          in_valid;
  logic [CW-1:0] in_data;
  logic          in_almostfull;
  logic [AL-1:0] wr_req_addr;
  logic [MD-1:0] wr_req_mdata;
  logic [CW-1:0] wr_req_data;
  logic          wr_req_en;
  logic          wr_req_almostfull;
  logic          wr_rsp0_valid;
  logic          wr_rsp1_valid;
  logic          done;
  logic          overflow;

  logic auto_rsp = 1'b0;
  logic auto_q   = 1'b0;
  logic man0     = 1'b0;
  logic man1     = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_rise = -1;
  logic done_d = 1'b0;

  logic [AL-1:0] q_addr [$];
  logic [MD-1:0] q_md   [$];
  logic [CW-1:0] q_dat  [$];
  int            q_cyc  [$];

  assign wr_rsp0_valid = auto_q | man0;
  assign wr_rsp1_valid = man1;

  wr_stream_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .num_cl            (num_cl),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_almostfull     (in_almostfull),
    .wr_req_addr       (wr_req_addr),
    .wr_req_mdata      (wr_req_mdata),
    .wr_req_data       (wr_req_data),
    .wr_req_en         (wr_req_en),
    .wr_req_almostfull (wr_req_almostfull),
    .wr_rsp0_valid     (wr_rsp0_valid),
    .wr_rsp0_mdata     ('0),
    .wr_rsp1_valid     (wr_rsp1_valid),
    .wr_rsp1_mdata     ('0),
    .done              (done),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) auto_q = auto_rsp && wr_req_en;

  always @(posedge clk) begin
    #1;
    if (wr_req_en) begin
      q_addr.push_back(wr_req_addr);
      q_md.push_back(wr_req_mdata);
      q_dat.push_back(wr_req_data);
      q_cyc.push_back(cyc);
    end
    if (done && !done_d)
      done_rise = cyc;
    done_d = done;
  end

  task automatic check(input string tag,
                       input logic [CW-1:0] got,
                       input logic [CW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] pat(input int k);
    logic [63:0] w;
    w = 64'hC0DE_0000_0000_0000 | 64'(k);
    return {8{w}};
  endfunction

  task automatic clr_q();
    q_addr.delete();
    q_md.delete();
    q_dat.delete();
    q_cyc.delete();
  endtask

  task automatic start_job(input logic [AL-1:0] b, input logic [31:0] n);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    num_cl = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_en(input string tag, input int n, input int budget);
    int k = 0;
    while (q_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, q_cyc.size(), n);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic send(input int n, input int base_k);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = pat(base_k + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [AL-1:0] wrap_exp [4];
  int t_in;
  int w0;
  int r1;
  int hits;

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    num_cl = '0;
    in_valid = 1'b0;
    in_data = '0;
    wr_req_almostfull = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_en", wr_req_en, 1'b0);
    check("rst_addr", wr_req_addr, '0);
    check("rst_afull", in_almostfull, 1'b0);

    // basic job: 4 lines from 0x100
    clr_q();
    auto_rsp = 1'b1;
    start_job(58'h100, 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) t_in = cyc;
      in_valid = 1'b1;
      in_data = pat(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_en("t1_cnt", 4, 40);
    for (int i = 0; i < 4 && i < q_cyc.size(); i++) begin
      check($sformatf("t1_addr%0d", i), q_addr[i], 58'h100 + 58'(i));
      check($sformatf("t1_md%0d", i), q_md[i], 14'(i));
      check($sformatf("t1_dat%0d", i), q_dat[i], pat(i));
    end
    if (q_cyc.size() > 0)
      check("t1_lat", q_cyc[0] - t_in, 2);
    wait_done("t1_done", 40);
    check("t1_ovf", overflow, 1'b0);

    // throttle for 10 cycles mid-job
    clr_q();
    start_job(58'h200, 32'd8);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) w0 = cyc;
      in_valid = (i < 8);
      in_data = pat(100 + i);
      wr_req_almostfull = (i >= 2);
    end
    @(negedge clk);
    wr_req_almostfull = 1'b0;
    in_valid = 1'b0;
    wait_en("t2_cnt", 8, 60);
    hits = 0;
    for (int i = 0; i < q_cyc.size(); i++)
      if (q_cyc[i] > w0 && q_cyc[i] <= w0 + 10) hits++;
    check("t2_thr_en", hits, 0);
    if (q_cyc.size() > 1)
      check("t2_resume", q_cyc[1], w0 + 11);
    for (int i = 0; i < 8 && i < q_cyc.size(); i++) begin
      check($sformatf("t2_dat%0d", i), q_dat[i], pat(100 + i));
      check($sformatf("t2_md%0d", i), q_md[i], 14'(i));
    end
    check("t2_ovf", overflow, 1'b0);
    wait_done("t2_done", 40);

    // fill to overflow with requests throttled
    clr_q();
    auto_rsp = 1'b0;
    wr_req_almostfull = 1'b1;
    start_job(58'h0, 32'd64);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i == 27) check("t3_af27", in_almostfull, 1'b0);
      if (i == 28) check("t3_af28", in_almostfull, 1'b1);
      if (i == 32) check("t3_ovf32", overflow, 1'b0);
      if (i == 33) check("t3_ovf33", overflow, 1'b1);
      in_valid = 1'b1;
      in_data = pat(200 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("t3_noreq", q_cyc.size(), 0);
    wr_req_almostfull = 1'b0;
    wait_en("t3_cnt", 32, 80);
    repeat (3) @(negedge clk);
    check("t3_cnt_final", q_cyc.size(), 32);
    if (q_cyc.size() == 32) begin
      check("t3_first", q_dat[0], pat(200));
      check("t3_last", q_dat[31], pat(231));
      check("t3_last_addr", q_addr[31], 58'd31);
    end
    do_reset();

    // done timing against responses
    clr_q();
    done_rise = -1;
    start_job(58'h40, 32'd3);
    send(3, 300);
    wait_en("t4_cnt", 3, 40);
`ifdef WR_RSP_TRACK_EN
    @(negedge clk);
    check("t4_done_pre", done, 1'b0);
    r1 = cyc;
    man0 = 1'b1;
    man1 = 1'b1;
    @(negedge clk);
    man1 = 1'b0;
    @(negedge clk);
    man0 = 1'b0;
    check("t4_done_early", done, 1'b0);
    @(negedge clk);
    check("t4_done", done, 1'b1);
    check("t4_rise", done_rise, r1 + 3);
`else
    repeat (2) @(negedge clk);
    check("t4_done", done, 1'b1);
    if (q_cyc.size() == 3)
      check("t4_rise", done_rise, q_cyc[2] + 1);
`endif

    // address wrap at the top of the space
    clr_q();
    auto_rsp = 1'b1;
    wrap_exp[0] = 58'h3FF_FFFF_FFFF_FFFE;
    wrap_exp[1] = 58'h3FF_FFFF_FFFF_FFFF;
    wrap_exp[2] = 58'h0;
    wrap_exp[3] = 58'h1;
    start_job(58'h3FF_FFFF_FFFF_FFFE, 32'd4);
    send(4, 400);
    wait_en("t5_cnt", 4, 40);
    for (int i = 0; i < 4 && i < q_cyc.size(); i++)
      check($sformatf("t5_addr%0d", i), q_addr[i], wrap_exp[i]);
    wait_done("t5_done", 40);

    // reset mid-job, then an empty job
    clr_q();
    auto_rsp = 1'b0;
    start_job(58'h300, 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 3) begin
        check("t6_pre_cnt", q_cyc.size(), 2);
        reset_n = 1'b0;
      end
      in_valid = 1'b1;
      in_data = pat(500 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_no_req", q_cyc.size(), 2);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_afull", in_almostfull, 1'b0);
    start_job(58'h0, 32'd0);
    check("t6_done0", done, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_done_hold", done, 1'b1);
    check("t6_no_req2", q_cyc.size(), 2);
    check("t6_ovf", overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
